// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: instruction fetch front end.
// Issues one word-addressed read at a time to instruction memory. Returned
// words are queued with their PCs in a small prefetch FIFO that feeds decode.
// A redirect flushes the FIFO and restarts fetch at a new PC. If a response
// is still in flight, that response is discarded when it arrives.
//
// Handshakes:
//   memory : a request is accepted on a cycle with mem_req_o=1 and mem_gnt_i=1.
//            Once raised, mem_req_o and mem_addr_o hold until that cycle; only a
//            redirect may withdraw them. Exactly one mem_rvalid_i follows each
//            grant, no earlier than the next cycle.
//   decode : the head entry transfers on a cycle with instr_valid_o=1 and
//            instr_ready_i=1. Once raised, instr_valid_o holds until that
//            transfer, unless a redirect flushes the buffer.
module rv_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         fetch_en_i,
    // instruction memory port
    output logic                         mem_req_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
    // control-flow redirect
    input  logic                         redirect_i,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc_i,
    // decode port
    output logic                         instr_valid_o,
    input  logic                         instr_ready_i,
    output logic [DATA_WIDTH-1:0]        instr_o,
    output logic [ADDR_WIDTH-1:0]        instr_pc_o,
    // debug visibility of internal state
    output logic [1:0]                   dbg_state_o,
    output logic [$clog2(DEPTH+1)-1:0]   dbg_count_o,
    output logic                         dbg_discard_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // IDLE: no request, nothing in flight
    // REQ : request presented, waiting for grant
    // WAIT: granted, waiting for read data
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    discard_q, discard_d;
    logic [ADDR_WIDTH-1:0]   pc_q;        // address of the next request
    logic [ADDR_WIDTH-1:0]   out_pc_q;    // address of the request in flight
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        rptr_q, wptr_q;
    logic [DATA_WIDTH-1:0]   data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_mem   [DEPTH];

    logic                    granted;
    logic                    push;
    logic                    pop;

    // A redirect withdraws any pending request in the same cycle, so a
    // grant that coincides with a redirect is ignored.
    assign mem_req_o  = (state_q == REQ) && !redirect_i;
    assign mem_addr_o = pc_q;
    assign granted    = mem_req_o && mem_gnt_i;

    // Responses are accepted only while one is expected. A response that
    // arrives after a redirect, or during one, belongs to the old stream and
    // is dropped.
    assign push = (state_q == WAIT) && mem_rvalid_i && !discard_q && !redirect_i;

    assign instr_valid_o = (count_q != '0);
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;

    // The head is forced to zero when the buffer is empty, so it reads zero
    // during reset without needing a clock.
    assign instr_o    = instr_valid_o ? data_mem[rptr_q] : '0;
    assign instr_pc_o = instr_valid_o ? pc_mem[rptr_q]   : '0;

    assign dbg_state_o   = state_q;
    assign dbg_count_o   = count_q;
    assign dbg_discard_o = discard_q;

    // Buffer occupancy after this cycle's push, pop and flush.
    always_comb begin
        count_d = count_q;
        if (redirect_i) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Fetch FSM next-state. A new request is issued only when nothing is in
    // flight and the buffer will still have room after this cycle. This
    // guarantees the buffer cannot overflow.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                if (!redirect_i && fetch_en_i && (count_q < FULL_CNT)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    state_d = IDLE;
                end else if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    if (mem_rvalid_i) begin
                        // The stale response arrives now, so nothing is left in flight.
                        state_d   = IDLE;
                        discard_d = 1'b0;
                    end else begin
                        // The stale response is still to come; drop it when it lands.
                        state_d   = WAIT;
                        discard_d = 1'b1;
                    end
                end else if (mem_rvalid_i) begin
                    discard_d = 1'b0;
                    if (fetch_en_i && (count_d < FULL_CNT)) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
        endcase
    end

    // FSM state and discard flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // Fetch PC: reload on redirect, otherwise advance by one word per grant.
    // The granted address is kept for tagging the response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= RESET_PC;
            out_pc_q <= '0;
        end else begin
            if (redirect_i) begin
                pc_q <= redirect_pc_i;
            end else if (granted) begin
                pc_q <= pc_q + ADDR_WIDTH'(1);
            end
            if (granted) begin
                out_pc_q <= pc_q;
            end
        end
    end

    // Buffer pointers and occupancy. A redirect empties the buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
        end else begin
            count_q <= count_d;
            if (redirect_i) begin
                rptr_q <= '0;
                wptr_q <= '0;
            end else begin
                if (push) begin
                    wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
                end
            end
        end
    end

    // Buffer storage. The contents need no reset because the output is
    // qualified by the occupancy.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wptr_q] <= mem_rdata_i;
            pc_mem[wptr_q]   <= out_pc_q;
        end
    end

`ifndef SYNTHESIS
    // The issue gating must never let a response land in a full buffer.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(push && (count_q == FULL_CNT)));
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed vector table plus hand-written sequences for
// rv_fetch_unit (ADDR_WIDTH=12, DATA_WIDTH=32, DEPTH=2, RESET_PC=0).
module tb_rv_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_en_i;
    logic        mem_req_o;
    logic [11:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [11:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [11:0] instr_pc_o;
    logic [1:0]  dbg_state_o;
    logic [1:0]  dbg_count_o;
    logic        dbg_discard_o;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    rv_fetch_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .fetch_en_i    (fetch_en_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .dbg_state_o   (dbg_state_o),
        .dbg_count_o   (dbg_count_o),
        .dbg_discard_o (dbg_discard_o)
    );

    // ---------------- vector table ----------------
    typedef struct {
        string       tag;
        bit          rst;
        bit          fe;
        bit          gnt;
        bit          rv;
        logic [31:0] rdata;
        bit          redir;
        logic [11:0] rpc;
        bit          rdy;
        bit          e_req;
        logic [11:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [11:0] e_pc;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    logic [43:0] exp_q[$];

    function automatic logic [31:0] word_of(input logic [11:0] a);
        return {20'hABCDE, a};
    endfunction

    task automatic add(input string tag, input bit rst, input bit fe, input bit gnt,
                       input bit rv, input logic [31:0] rdata, input bit redir,
                       input logic [11:0] rpc, input bit rdy, input bit e_req,
                       input logic [11:0] e_addr, input bit e_valid,
                       input logic [31:0] e_instr, input logic [11:0] e_pc,
                       input logic [1:0] e_cnt);
        vec_t v;
        v.tag = tag; v.rst = rst; v.fe = fe; v.gnt = gnt; v.rv = rv;
        v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_idle();
        fetch_en_i    = 1'b0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
    endtask

    // Called at posedge+1; applies one cycle of inputs, checks, ends at next posedge+1.
    task automatic apply_vec(input vec_t v);
        if (v.rst) begin
            drive_idle();
            rst_ni = 1'b0;
            @(posedge clk_i);
            @(posedge clk_i);
            #1;
            rst_ni = 1'b1;
        end
        fetch_en_i    = v.fe;
        mem_gnt_i     = v.gnt;
        mem_rvalid_i  = v.rv;
        mem_rdata_i   = v.rdata;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        instr_ready_i = v.rdy;
        #1;
        chk({v.tag, ".req"},   64'(mem_req_o),     64'(v.e_req));
        chk({v.tag, ".addr"},  64'(mem_addr_o),    64'(v.e_addr));
        chk({v.tag, ".valid"}, 64'(instr_valid_o), 64'(v.e_valid));
        chk({v.tag, ".count"}, 64'(dbg_count_o),   64'(v.e_cnt));
        if (v.e_valid) begin
            chk({v.tag, ".instr"}, 64'(instr_o),    64'(v.e_instr));
            chk({v.tag, ".pc"},    64'(instr_pc_o), 64'(v.e_pc));
        end
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e_start;
        int got;
        int cyc;
        int gnt_wait;
        int rv_wait;
        int n_gnt;
        bit outstanding;
        logic [11:0] out_addr;
        int gw_pat[6];
        int rd_pat[6];
        bit rdy_pat[5];

        drive_idle();
        rst_ni = 1'b0;

        // Reset values, checked before the first clock edge.
        #2;
        chk("rst.req",     64'(mem_req_o),     64'd0);
        chk("rst.addr",    64'(mem_addr_o),    64'd0);
        chk("rst.valid",   64'(instr_valid_o), 64'd0);
        chk("rst.instr",   64'(instr_o),       64'd0);
        chk("rst.pc",      64'(instr_pc_o),    64'd0);
        chk("rst.count",   64'(dbg_count_o),   64'd0);
        chk("rst.discard", 64'(dbg_discard_o), 64'd0);
        chk("rst.state",   64'(dbg_state_o),   64'd0);
        @(posedge clk_i);
        #1;

        // A: streaming fetch with immediate grant and a one-cycle response.
        //  tag   rst fe gnt rv rdata              rd rpc      rdy | req addr    v  instr              pc       cnt
        add("A0", 1, 1, 0, 0, 0,                 0, 12'h000, 1,  0, 12'h000, 0, 0,                 12'h000, 0);
        add("A1", 0, 1, 1, 0, 0,                 0, 12'h000, 1,  1, 12'h000, 0, 0,                 12'h000, 0);
        add("A2", 0, 1, 0, 1, word_of(12'h000),  0, 12'h000, 1,  0, 12'h001, 0, 0,                 12'h000, 0);
        add("A3", 0, 1, 1, 0, 0,                 0, 12'h000, 1,  1, 12'h001, 1, word_of(12'h000),  12'h000, 1);
        add("A4", 0, 1, 0, 1, word_of(12'h001),  0, 12'h000, 1,  0, 12'h002, 0, 0,                 12'h000, 0);
        add("A5", 0, 1, 1, 0, 0,                 0, 12'h000, 1,  1, 12'h002, 1, word_of(12'h001),  12'h001, 1);
        add("A6", 0, 1, 0, 1, word_of(12'h002),  0, 12'h000, 1,  0, 12'h003, 0, 0,                 12'h000, 0);
        add("A7", 0, 1, 0, 0, 0,                 0, 12'h000, 1,  1, 12'h003, 1, word_of(12'h002),  12'h002, 1);
        // B: decode stalled, buffer fills to two and fetching stops; then drains in order.
        add("B0", 1, 1, 0, 0, 0,                 0, 12'h000, 0,  0, 12'h000, 0, 0,                 12'h000, 0);
        add("B1", 0, 1, 1, 0, 0,                 0, 12'h000, 0,  1, 12'h000, 0, 0,                 12'h000, 0);
        add("B2", 0, 1, 0, 1, word_of(12'h000),  0, 12'h000, 0,  0, 12'h001, 0, 0,                 12'h000, 0);
        add("B3", 0, 1, 1, 0, 0,                 0, 12'h000, 0,  1, 12'h001, 1, word_of(12'h000),  12'h000, 1);
        add("B4", 0, 1, 0, 1, word_of(12'h001),  0, 12'h000, 0,  0, 12'h002, 1, word_of(12'h000),  12'h000, 1);
        add("B5", 0, 1, 1, 0, 0,                 0, 12'h000, 0,  0, 12'h002, 1, word_of(12'h000),  12'h000, 2);
        add("B6", 0, 1, 0, 0, 0,                 0, 12'h000, 0,  0, 12'h002, 1, word_of(12'h000),  12'h000, 2);
        add("B7", 0, 1, 0, 0, 0,                 0, 12'h000, 1,  0, 12'h002, 1, word_of(12'h000),  12'h000, 2);
        add("B8", 0, 1, 0, 0, 0,                 0, 12'h000, 1,  0, 12'h002, 1, word_of(12'h001),  12'h001, 1);
        add("B9", 0, 1, 0, 0, 0,                 0, 12'h000, 1,  1, 12'h002, 0, 0,                 12'h000, 0);
        // C: redirect to 0x100 while waiting; the late response is dropped.
        add("C0", 1, 1, 0, 0, 0,                 0, 12'h000, 0,  0, 12'h000, 0, 0,                 12'h000, 0);
        add("C1", 0, 1, 1, 0, 0,                 0, 12'h000, 0,  1, 12'h000, 0, 0,                 12'h000, 0);
        add("C2", 0, 1, 0, 0, 0,                 1, 12'h100, 0,  0, 12'h001, 0, 0,                 12'h000, 0);
        add("C3", 0, 1, 0, 0, 0,                 0, 12'h000, 0,  0, 12'h100, 0, 0,                 12'h000, 0);
        add("C4", 0, 1, 0, 1, 32'hDEADBEEF,      0, 12'h000, 0,  0, 12'h100, 0, 0,                 12'h000, 0);
        add("C5", 0, 1, 1, 0, 0,                 0, 12'h000, 0,  1, 12'h100, 0, 0,                 12'h000, 0);
        add("C6", 0, 1, 0, 1, word_of(12'h100),  0, 12'h000, 0,  0, 12'h101, 0, 0,                 12'h000, 0);
        add("C7", 0, 1, 0, 0, 0,                 0, 12'h000, 1,  1, 12'h101, 1, word_of(12'h100),  12'h100, 1);
        // D: grant held low for three cycles while fetch_en drops.
        add("D0", 1, 1, 0, 0, 0,                 0, 12'h000, 0,  0, 12'h000, 0, 0,                 12'h000, 0);
        add("D1", 0, 0, 0, 0, 0,                 0, 12'h000, 0,  1, 12'h000, 0, 0,                 12'h000, 0);
        add("D2", 0, 0, 0, 0, 0,                 0, 12'h000, 0,  1, 12'h000, 0, 0,                 12'h000, 0);
        add("D3", 0, 0, 0, 0, 0,                 0, 12'h000, 0,  1, 12'h000, 0, 0,                 12'h000, 0);
        add("D4", 0, 0, 1, 0, 0,                 0, 12'h000, 0,  1, 12'h000, 0, 0,                 12'h000, 0);
        add("D5", 0, 0, 0, 1, word_of(12'h000),  0, 12'h000, 0,  0, 12'h001, 0, 0,                 12'h000, 0);
        add("D6", 0, 0, 0, 0, 0,                 0, 12'h000, 0,  0, 12'h001, 1, word_of(12'h000),  12'h000, 1);
        add("D7", 0, 0, 1, 0, 0,                 0, 12'h000, 0,  0, 12'h001, 1, word_of(12'h000),  12'h000, 1);
        // E: redirect in the same cycle as a pop and a response.
        e_start = vecs.size();
        add("E0", 1, 1, 0, 0, 0,                 0, 12'h000, 0,  0, 12'h000, 0, 0,                 12'h000, 0);
        add("E1", 0, 1, 1, 0, 0,                 0, 12'h000, 0,  1, 12'h000, 0, 0,                 12'h000, 0);
        add("E2", 0, 1, 0, 1, word_of(12'h000),  0, 12'h000, 0,  0, 12'h001, 0, 0,                 12'h000, 0);
        add("E3", 0, 1, 1, 0, 0,                 0, 12'h000, 0,  1, 12'h001, 1, word_of(12'h000),  12'h000, 1);
        add("E4", 0, 1, 0, 1, word_of(12'h001),  1, 12'h2A0, 1,  0, 12'h002, 1, word_of(12'h000),  12'h000, 1);
        add("E5", 0, 1, 0, 0, 0,                 0, 12'h000, 1,  0, 12'h2A0, 0, 0,                 12'h000, 0);
        add("E6", 0, 1, 0, 0, 0,                 0, 12'h000, 1,  1, 12'h2A0, 0, 0,                 12'h000, 0);
        // F: redirect during REQ masks the grant; PC wraps from 0xFFF to 0x000.
        add("F0", 1, 1, 0, 0, 0,                 0, 12'h000, 0,  0, 12'h000, 0, 0,                 12'h000, 0);
        add("F1", 0, 1, 1, 0, 0,                 1, 12'hFFF, 0,  0, 12'h000, 0, 0,                 12'h000, 0);
        add("F2", 0, 1, 0, 0, 0,                 0, 12'h000, 0,  0, 12'hFFF, 0, 0,                 12'h000, 0);
        add("F3", 0, 1, 1, 0, 0,                 0, 12'h000, 0,  1, 12'hFFF, 0, 0,                 12'h000, 0);
        add("F4", 0, 1, 0, 1, word_of(12'hFFF),  0, 12'h000, 0,  0, 12'h000, 0, 0,                 12'h000, 0);
        add("F5", 0, 1, 0, 0, 0,                 0, 12'h000, 1,  1, 12'h000, 1, word_of(12'hFFF),  12'hFFF, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i]);
        end

        // Reset while waiting with one entry buffered: the outputs clear without a clock edge.
        for (int i = 0; i < 4; i++) begin
            apply_vec(vecs[e_start + i]);
        end
        mem_gnt_i = 1'b0;
        #1;
        chk("arst.pre_state", 64'(dbg_state_o), 64'd2);
        chk("arst.pre_count", 64'(dbg_count_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("arst.valid", 64'(instr_valid_o), 64'd0);
        chk("arst.req",   64'(mem_req_o),     64'd0);
        chk("arst.addr",  64'(mem_addr_o),    64'd0);
        chk("arst.instr", 64'(instr_o),       64'd0);
        chk("arst.count", 64'(dbg_count_o),   64'd0);
        chk("arst.state", 64'(dbg_state_o),   64'd0);
        // A response in the cycle reset is released must be dropped.
        fetch_en_i   = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BAD0BAD;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        chk("arst.rel_req",   64'(mem_req_o),     64'd0);
        chk("arst.rel_valid", 64'(instr_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        mem_rvalid_i = 1'b0;
        #1;
        chk("arst.restart_req",   64'(mem_req_o),     64'd1);
        chk("arst.restart_addr",  64'(mem_addr_o),    64'd0);
        chk("arst.restart_valid", 64'(instr_valid_o), 64'd0);
        chk("arst.restart_count", 64'(dbg_count_o),   64'd0);

        // Scoreboard run: variable grant/response latency and decode stalls.
        drive_idle();
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        gw_pat  = '{0, 2, 1, 0, 3, 1};
        rd_pat  = '{0, 1, 2, 0, 1, 0};
        rdy_pat = '{1, 0, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({12'(i), word_of(12'(i))});
        end
        got = 0;
        cyc = 0;
        n_gnt = 0;
        gnt_wait = gw_pat[0];
        rv_wait = 0;
        outstanding = 1'b0;
        out_addr = '0;
        fetch_en_i = 1'b1;
        while (got < 6 && cyc < 300) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (outstanding) begin
                if (rv_wait == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = word_of(out_addr);
                    outstanding  = 1'b0;
                end else begin
                    rv_wait--;
                end
            end
            #1;
            if (mem_req_o) begin
                if (gnt_wait == 0) begin
                    mem_gnt_i   = 1'b1;
                    out_addr    = mem_addr_o;
                    outstanding = 1'b1;
                    rv_wait     = rd_pat[n_gnt % 6];
                    n_gnt++;
                    gnt_wait    = gw_pat[n_gnt % 6];
                end else begin
                    gnt_wait--;
                end
            end
            instr_ready_i = rdy_pat[cyc % 5];
            #1;
            if (instr_valid_o && instr_ready_i) begin
                got++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb.extra: got pc %0h with no entry expected", instr_pc_o);
                end else begin
                    chk("sb.deliver", 64'({instr_pc_o, instr_o}), 64'(exp_q.pop_front()));
                end
            end
            @(posedge clk_i);
            #1;
            cyc++;
        end
        checks++;
        if (got < 6) begin
            errors++;
            $display("FAIL sb.timeout: got %0d deliveries expected 6", got);
        end

        drive_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_fetch_unit.md
RV_FETCH_UNIT -- requirements
Module: rv_fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, sets the width of the instruction word address.
REQ-002 Parameter DATA_WIDTH, default 32, sets the instruction word width.
REQ-003 Parameter DEPTH, default 2, sets the number of prefetch buffer entries.
REQ-004 Parameter RESET_PC, default 0, sets the first fetch address after reset.
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 fetch_en_i  input  1  permits new memory requests.
REQ-008 mem_req_o  output  1  memory read request.
REQ-009 mem_addr_o  output  ADDR_WIDTH  word address of the request.
REQ-010 mem_gnt_i  input  1  request accepted this cycle.
REQ-011 mem_rvalid_i  input  1  read data valid this cycle.
REQ-012 mem_rdata_i  input  DATA_WIDTH  read data.
REQ-013 redirect_i  input  1  flush and restart fetch.
REQ-014 redirect_pc_i  input  ADDR_WIDTH  new fetch address.
REQ-015 instr_valid_o  output  1  buffer head holds a valid instruction.
REQ-016 instr_ready_i  input  1  decode accepts the head this cycle.
REQ-017 instr_o  output  DATA_WIDTH  head instruction word.
REQ-018 instr_pc_o  output  ADDR_WIDTH  word address of the head instruction.

Function
REQ-019 Word addressing: the fetch PC increments by 1 per granted request and wraps modulo 2^ADDR_WIDTH.
REQ-020 The memory handshake completes on a cycle with mem_req_o=1 and mem_gnt_i=1; mem_gnt_i is ignored while mem_req_o=0.
REQ-021 Once mem_req_o is asserted, it and mem_addr_o stay stable until grant, even if fetch_en_i drops; redirect is the only exception.
REQ-022 At most one request is outstanding; exactly one mem_rvalid_i is returned per grant, at least 1 cycle after grant.
REQ-023 The FSM has three states. IDLE: mem_req_o=0. REQ: mem_req_o=1. WAIT: granted, awaiting rvalid, mem_req_o=0.
REQ-024 IDLE->REQ when fetch_en_i=1, count<DEPTH and no redirect; REQ->WAIT on grant; WAIT->REQ on rvalid if the issue condition holds, otherwise WAIT->IDLE.
REQ-025 A non-discarded rvalid pushes {pc,rdata} into the FIFO; the entry becomes visible on instr_valid_o the next cycle, with no bypass.
REQ-026 Pop occurs on instr_valid_o and instr_ready_i; a simultaneous push and pop leaves count unchanged; order is strictly FIFO.
REQ-027 instr_valid_o = (count!=0); instr_o and instr_pc_o are don't-care when not valid.
REQ-028 In the redirect cycle: mem_req_o=0, the FIFO is flushed (count=0 next cycle), the fetch PC is loaded with redirect_pc_i, and the state goes to IDLE, or to WAIT if a grant is outstanding.
REQ-029 Redirect with a grant outstanding sets a discard flag; the matching rvalid, including one in the redirect cycle itself, is dropped and clears the flag.
REQ-030 Redirect takes priority over push, pop and issue in the same cycle.
REQ-031 Since the issue condition requires count<DEPTH with zero outstanding, overflow is impossible; a push into a full FIFO is an assertion failure.

Reset
REQ-032 While rst_ni=0, without any clock: mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, count=0, discard=0, state=IDLE.
REQ-033 A reset mid-transaction abandons the outstanding request; any rvalid in the cycle rst_ni rises is dropped.

Verification
REQ-034 Reset release with fetch_en_i=1, gnt immediate, rvalid 1 cycle later, ready=1 -> mem_addr_o 0,1,2,...; instr_pc_o 0,1,2 carry the matching rdata in order.
REQ-035 instr_ready_i=0 -> after 2 pushes, count=2 and mem_req_o stays 0; ready=1 -> pc0 then pc1 drain on consecutive cycles, then fetching resumes at pc2.
REQ-036 Redirect to 0x100 while in WAIT -> the late rvalid data is not delivered, the next mem_addr_o is 0x100, and the first instr_pc_o is 0x100.
REQ-037 mem_gnt_i held low for 3 cycles while fetch_en_i drops -> mem_req_o and mem_addr_o stay stable until grant; no further request after the response.
REQ-038 rst_ni asserted mid-WAIT with count=1 -> instr_valid_o=0 and mem_req_o=0 immediately with no clock edge; after release, fetch restarts at RESET_PC.
REQ-039 Redirect in the same cycle as a pop and an rvalid -> the FIFO is empty next cycle, the rvalid data is dropped, and the next mem_addr_o equals redirect_pc_i.
